// File: rtl/snes_clk_pkg.sv
// Shared definitions for the SNES clock / reset generator.
//   - clk_state_e : power-up sequencer states (WAIT_LOCK -> HOLD -> RUN)
//   - CPU_SPEED_* : cpu_speed input encodings
//   - CPU_LEN_*   : CPU cycle length in master cycles for each encoding
//   - cpu_len_of  : maps a cpu_speed code to its cycle length
package snes_clk_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } clk_state_e;

    localparam logic [1:0] CPU_SPEED_6     = 2'd0;
    localparam logic [1:0] CPU_SPEED_8     = 2'd1;
    localparam logic [1:0] CPU_SPEED_12    = 2'd2;
    localparam logic [1:0] CPU_SPEED_8_ALT = 2'd3;

    localparam logic [3:0] CPU_LEN_6  = 4'd6;
    localparam logic [3:0] CPU_LEN_8  = 4'd8;
    localparam logic [3:0] CPU_LEN_12 = 4'd12;

    function automatic logic [3:0] cpu_len_of(input logic [1:0] speed);
        case (speed)
            CPU_SPEED_6:                  cpu_len_of = CPU_LEN_6;
            CPU_SPEED_8, CPU_SPEED_8_ALT: cpu_len_of = CPU_LEN_8;
            CPU_SPEED_12:                 cpu_len_of = CPU_LEN_12;
            default:                      cpu_len_of = CPU_LEN_6;
        endcase
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchroniser for a single asynchronous level (PLL lock).
// Ports:
//   clk      : destination clock
//   reset    : synchronous active-high reset, clears both flops
//   async_in : asynchronous input level
//   sync_out : synchronised level (second flop)
module lock_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/snes_clkgen_rst.sv
// SNES clock-enable and reset generator running on the fast PLL clock.
// Waits for a stable PLL lock, holds the core in reset for RST_HOLD clocks,
// then produces master / CPU / dot clock enables.
// Parameters:
//   MCLK_DIV : fast clocks per master-clock enable (2..15)
//   RST_HOLD : fast clocks of stable lock before reset release (4..65535)
// Ports:
//   clk        : fast system clock
//   reset      : synchronous active-high reset
//   pll_lock   : PLL lock, asynchronous to clk
//   cpu_speed  : CPU cycle length select (0=6, 1=8, 2=12, 3=8 master cycles)
//   pause      : freezes all counters and suppresses enables while high
//   snes_reset : active-high reset to the SNES core
//   mclk_ce    : one-clk pulse per master cycle
//   cpu_ce     : one-clk pulse per CPU cycle, coincident with mclk_ce
//   dot_ce     : one-clk pulse every 4th master cycle, coincident with mclk_ce
//   running    : high while in RUN
//   state_dbg  : current sequencer state, for observation only
// Build option:
//   CLKGEN_LOCK_LOSS_RESET_EN : when defined, losing lock in RUN returns to
//   WAIT_LOCK and re-asserts snes_reset; otherwise RUN is left only by reset.
module snes_clkgen_rst
    import snes_clk_pkg::*;
#(
    parameter int MCLK_DIV = 4,
    parameter int RST_HOLD = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic [1:0] cpu_speed,
    input  logic       pause,
    output logic       snes_reset,
    output logic       mclk_ce,
    output logic       cpu_ce,
    output logic       dot_ce,
    output logic       running,
    output clk_state_e state_dbg
);

    localparam logic [3:0]  DIV_LAST  = 4'(MCLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

    logic lock_s;

    lock_sync u_lock_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pll_lock),
        .sync_out (lock_s)
    );

    clk_state_e  state_q, state_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]  div_q, div_d;
    logic [3:0]  cpu_cnt_q, cpu_cnt_d;
    logic [3:0]  cpu_len_q, cpu_len_d;
    logic [1:0]  dot_q, dot_d;
    logic        snes_reset_q, snes_reset_d;
    logic        mclk_ce_q, mclk_ce_d;
    logic        cpu_ce_q, cpu_ce_d;
    logic        dot_ce_q, dot_ce_d;
    logic        running_q, running_d;
    logic        mclk_tick;
    logic        cpu_wrap;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        div_d      = div_q;
        cpu_cnt_d  = cpu_cnt_q;
        cpu_len_d  = cpu_len_q;
        dot_d      = dot_q;
        mclk_tick  = 1'b0;
        cpu_wrap   = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                hold_cnt_d = '0;
                if (lock_s) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            ST_RUN: begin
`ifdef CLKGEN_LOCK_LOSS_RESET_EN
                if (!lock_s) state_d = ST_WAIT_LOCK;
`endif
                // While paused every counter simply keeps its value.
                if (!pause) begin
                    if (div_q == DIV_LAST) begin
                        div_d     = '0;
                        mclk_tick = 1'b1;
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                    if (mclk_tick) begin
                        dot_d = dot_q + 2'd1;
                        if (cpu_cnt_q == cpu_len_q - 4'd1) begin
                            cpu_wrap  = 1'b1;
                            cpu_cnt_d = '0;
                            // New speed only takes effect at a cycle boundary.
                            cpu_len_d = cpu_len_of(cpu_speed);
                        end else begin
                            cpu_cnt_d = cpu_cnt_q + 4'd1;
                        end
                    end
                end
            end
            default: state_d = ST_WAIT_LOCK;
        endcase

        // Outside RUN the enable counters sit at zero and the cycle length
        // tracks cpu_speed, so RUN always starts on a clean CPU cycle.
        if (state_q != ST_RUN) begin
            div_d     = '0;
            cpu_cnt_d = '0;
            dot_d     = '0;
            cpu_len_d = cpu_len_of(cpu_speed);
        end

        mclk_ce_d    = mclk_tick;
        cpu_ce_d     = mclk_tick && cpu_wrap;
        dot_ce_d     = mclk_tick && (dot_q == 2'd3);
        snes_reset_d = (state_q != ST_RUN);
        running_d    = (state_q == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_WAIT_LOCK;
            hold_cnt_q   <= '0;
            div_q        <= '0;
            cpu_cnt_q    <= '0;
            cpu_len_q    <= CPU_LEN_6;
            dot_q        <= '0;
            snes_reset_q <= 1'b1;
            mclk_ce_q    <= 1'b0;
            cpu_ce_q     <= 1'b0;
            dot_ce_q     <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            div_q        <= div_d;
            cpu_cnt_q    <= cpu_cnt_d;
            cpu_len_q    <= cpu_len_d;
            dot_q        <= dot_d;
            snes_reset_q <= snes_reset_d;
            mclk_ce_q    <= mclk_ce_d;
            cpu_ce_q     <= cpu_ce_d;
            dot_ce_q     <= dot_ce_d;
            running_q    <= running_d;
        end
    end

    assign snes_reset = snes_reset_q;
    assign mclk_ce    = mclk_ce_q;
    assign cpu_ce     = cpu_ce_q;
    assign dot_ce     = dot_ce_q;
    assign running    = running_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_snes_clkgen_rst.sv
// Testbench for snes_clkgen_rst (MCLK_DIV=4, RST_HOLD=16).
// cyc counts clock edges from a chosen origin; pulse scoreboards hold the
// edge numbers at which each enable is expected.
module tb_snes_clkgen_rst;
    import snes_clk_pkg::*;

    localparam int MCLK_DIV = 4;
    localparam int RST_HOLD = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic [1:0] cpu_speed;
    logic       pause;
    logic       snes_reset;
    logic       mclk_ce;
    logic       cpu_ce;
    logic       dot_ce;
    logic       running;
    clk_state_e state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] exp_mclk_q[$];
    logic [15:0] exp_cpu_q[$];
    logic [15:0] exp_dot_q[$];
    logic [15:0] exp_t;

    always #5 clk = ~clk;

    snes_clkgen_rst #(
        .MCLK_DIV (MCLK_DIV),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .cpu_speed  (cpu_speed),
        .pause      (pause),
        .snes_reset (snes_reset),
        .mclk_ce    (mclk_ce),
        .cpu_ce     (cpu_ce),
        .dot_ce     (dot_ce),
        .running    (running),
        .state_dbg  (state_dbg)
    );

    // Advance one clock, sample 1 time unit after the edge, and retire any
    // enable pulses against the scoreboard queues.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (mclk_ce === 1'b1) begin
            checks++;
            if (exp_mclk_q.size() == 0) begin
                errors++;
                $display("FAIL sb_mclk: pulse at cyc %0d, expected no pulse", cyc);
            end else begin
                exp_t = exp_mclk_q.pop_front();
                if (exp_t !== 16'(cyc)) begin
                    errors++;
                    $display("FAIL sb_mclk: pulse at cyc %0d, expected at cyc %0d", cyc, exp_t);
                end
            end
        end
        if (cpu_ce === 1'b1) begin
            checks++;
            if (exp_cpu_q.size() == 0) begin
                errors++;
                $display("FAIL sb_cpu: pulse at cyc %0d, expected no pulse", cyc);
            end else begin
                exp_t = exp_cpu_q.pop_front();
                if (exp_t !== 16'(cyc)) begin
                    errors++;
                    $display("FAIL sb_cpu: pulse at cyc %0d, expected at cyc %0d", cyc, exp_t);
                end
            end
        end
        if (dot_ce === 1'b1) begin
            checks++;
            if (exp_dot_q.size() == 0) begin
                errors++;
                $display("FAIL sb_dot: pulse at cyc %0d, expected no pulse", cyc);
            end else begin
                exp_t = exp_dot_q.pop_front();
                if (exp_t !== 16'(cyc)) begin
                    errors++;
                    $display("FAIL sb_dot: pulse at cyc %0d, expected at cyc %0d", cyc, exp_t);
                end
            end
        end
        if ((cpu_ce === 1'b1 || dot_ce === 1'b1) && mclk_ce !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL coincidence: cpu_ce=%b dot_ce=%b without mclk_ce at cyc %0d", cpu_ce, dot_ce, cyc);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        pll_lock  = 1'b0;
        pause     = 1'b0;
        cpu_speed = 2'd0;
        repeat ($urandom_range(2, 5)) step();
        checks++;
        if (snes_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_snes_reset: got %b, expected 1", snes_reset);
        end
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL reset_running: got %b, expected 0", running);
        end
        checks++;
        if ({mclk_ce, cpu_ce, dot_ce} !== 3'b000) begin
            errors++;
            $display("FAIL reset_enables: got %b, expected 000", {mclk_ce, cpu_ce, dot_ce});
        end
        checks++;
        if (state_dbg !== ST_WAIT_LOCK) begin
            errors++;
            $display("FAIL reset_state: got %0d, expected %0d", state_dbg, ST_WAIT_LOCK);
        end
        // Without lock the sequencer must stay put.
        reset = 1'b0;
        repeat (6) step();
        checks++;
        if (state_dbg !== ST_WAIT_LOCK || snes_reset !== 1'b1) begin
            errors++;
            $display("FAIL no_lock_idle: state %0d snes_reset %b, expected state %0d snes_reset 1",
                     state_dbg, snes_reset, ST_WAIT_LOCK);
        end
    endtask

    // Edge 1 is the first edge that samples pll_lock high; snes_reset must
    // still be high after edge 19 and low after edge 20 (2+16+1 edges later).
    task automatic test_lock_release();
        bit early_fall;
        early_fall = 1'b0;
        pll_lock   = 1'b1;
        cyc        = 0;
        while (cyc < 20) begin
            step();
            if (cyc < 20 && snes_reset !== 1'b1) early_fall = 1'b1;
            if (cyc == 3) begin
                checks++;
                if (state_dbg !== ST_HOLD) begin
                    errors++;
                    $display("FAIL hold_entry: state %0d at cyc 3, expected %0d", state_dbg, ST_HOLD);
                end
            end
            if (cyc == 19) begin
                checks++;
                if (state_dbg !== ST_RUN || running !== 1'b0) begin
                    errors++;
                    $display("FAIL run_entry: state %0d running %b at cyc 19, expected state %0d running 0",
                             state_dbg, running, ST_RUN);
                end
            end
        end
        checks++;
        if (early_fall) begin
            errors++;
            $display("FAIL reset_early: snes_reset low before cyc 20, expected high until cyc 20");
        end
        checks++;
        if (snes_reset !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: snes_reset %b running %b at cyc 20, expected 0 and 1",
                     snes_reset, running);
        end
    endtask

    // RUN began at edge 19, so mclk pulses land on 23 + 4k.
    task automatic test_run_counts();
        int n_mclk, n_cpu, n_dot;
        n_mclk = 0;
        n_cpu  = 0;
        n_dot  = 0;
        for (int t = 23; t <= 115; t += 4) exp_mclk_q.push_back(16'(t));
        for (int t = 43; t <= 115; t += 24) exp_cpu_q.push_back(16'(t));
        for (int t = 35; t <= 115; t += 16) exp_dot_q.push_back(16'(t));
        // Window covers edges 20..115 (96 clocks); edge 20 was stepped already.
        if (mclk_ce === 1'b1) n_mclk++;
        while (cyc < 115) begin
            step();
            if (mclk_ce === 1'b1) n_mclk++;
            if (cpu_ce === 1'b1) n_cpu++;
            if (dot_ce === 1'b1) n_dot++;
        end
        checks++;
        if (n_mclk != 24 || n_cpu != 4 || n_dot != 6) begin
            errors++;
            $display("FAIL run_counts: mclk %0d cpu %0d dot %0d, expected 24 4 6", n_mclk, n_cpu, n_dot);
        end
        checks++;
        if (exp_mclk_q.size() + exp_cpu_q.size() + exp_dot_q.size() != 0) begin
            errors++;
            $display("FAIL run_counts_pending: %0d/%0d/%0d pulses missing, expected 0/0/0",
                     exp_mclk_q.size(), exp_cpu_q.size(), exp_dot_q.size());
        end
        exp_mclk_q.delete(); exp_cpu_q.delete(); exp_dot_q.delete();
    endtask

    // A CPU cycle began at 115; switching to 12 mid-cycle must still end this
    // cycle at 6 master cycles (139) and the next one 12 later (187).
    task automatic test_speed_change();
        int chg;
        chg = $urandom_range(117, 137);
        for (int t = 119; t <= 187; t += 4) exp_mclk_q.push_back(16'(t));
        exp_cpu_q.push_back(16'd139);
        exp_cpu_q.push_back(16'd187);
        for (int t = 131; t <= 179; t += 16) exp_dot_q.push_back(16'(t));
        while (cyc < 190) begin
            step();
            if (cyc == chg) cpu_speed = 2'd2;
        end
        checks++;
        if (exp_mclk_q.size() + exp_cpu_q.size() + exp_dot_q.size() != 0) begin
            errors++;
            $display("FAIL speed_change_pending: %0d/%0d/%0d pulses missing, expected 0/0/0",
                     exp_mclk_q.size(), exp_cpu_q.size(), exp_dot_q.size());
        end
        exp_mclk_q.delete(); exp_cpu_q.delete(); exp_dot_q.delete();
    endtask

    // Divider is at 1 after edge 192; pausing for edges 193..199 pushes the
    // next master pulse from 195 to 202.
    task automatic test_pause();
        bit leak;
        leak = 1'b0;
        exp_mclk_q.push_back(16'd191);
        for (int t = 202; t <= 242; t += 4) exp_mclk_q.push_back(16'(t));
        exp_cpu_q.push_back(16'd242);
        for (int t = 202; t <= 234; t += 16) exp_dot_q.push_back(16'(t));
        while (cyc < 245) begin
            step();
            if (cyc >= 193 && cyc <= 201 && {mclk_ce, cpu_ce, dot_ce} !== 3'b000) leak = 1'b1;
            if (cyc == 192) pause = 1'b1;
            if (cyc == 199) pause = 1'b0;
            if (cyc == 202) begin
                checks++;
                if (mclk_ce !== 1'b1) begin
                    errors++;
                    $display("FAIL pause_resume: mclk_ce %b at cyc 202, expected 1", mclk_ce);
                end
            end
        end
        checks++;
        if (leak) begin
            errors++;
            $display("FAIL pause_quiet: enable seen during cyc 193..201, expected none");
        end
        checks++;
        if (exp_mclk_q.size() + exp_cpu_q.size() + exp_dot_q.size() != 0) begin
            errors++;
            $display("FAIL pause_pending: %0d/%0d/%0d pulses missing, expected 0/0/0",
                     exp_mclk_q.size(), exp_cpu_q.size(), exp_dot_q.size());
        end
        exp_mclk_q.delete(); exp_cpu_q.delete(); exp_dot_q.delete();
    endtask

    // pll_lock drops before edge 246; lock_s falls after edge 247.
    task automatic test_lock_loss();
        bit bad;
        bad = 1'b0;
        exp_mclk_q.push_back(16'd246);
`ifdef CLKGEN_LOCK_LOSS_RESET_EN
        pll_lock = 1'b0;
        while (cyc < 260) begin
            step();
            if (cyc >= 249 && snes_reset !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL lock_loss_reset: snes_reset low after cyc 249, expected 1");
        end
        checks++;
        if (state_dbg !== ST_WAIT_LOCK || running !== 1'b0) begin
            errors++;
            $display("FAIL lock_loss_state: state %0d running %b, expected %0d and 0",
                     state_dbg, running, ST_WAIT_LOCK);
        end
`else
        for (int t = 250; t <= 258; t += 4) exp_mclk_q.push_back(16'(t));
        exp_dot_q.push_back(16'd250);
        pll_lock = 1'b0;
        while (cyc < 260) begin
            step();
            if (snes_reset !== 1'b0 || running !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL lock_loss_ignored: snes_reset/running changed after lock loss, expected 0/1");
        end
        checks++;
        if (state_dbg !== ST_RUN) begin
            errors++;
            $display("FAIL lock_loss_state: state %0d, expected %0d", state_dbg, ST_RUN);
        end
`endif
        checks++;
        if (exp_mclk_q.size() + exp_cpu_q.size() + exp_dot_q.size() != 0) begin
            errors++;
            $display("FAIL lock_loss_pending: %0d/%0d/%0d pulses missing, expected 0/0/0",
                     exp_mclk_q.size(), exp_cpu_q.size(), exp_dot_q.size());
        end
        exp_mclk_q.delete(); exp_cpu_q.delete(); exp_dot_q.delete();
    endtask

    task automatic test_reset_pulses();
        // Reset while in HOLD.
        reset = 1'b1;
        step();
        reset    = 1'b0;
        pll_lock = 1'b1;
        cyc      = 0;
        while (cyc < 8) step();
        checks++;
        if (state_dbg !== ST_HOLD) begin
            errors++;
            $display("FAIL hold_before_reset: state %0d, expected %0d", state_dbg, ST_HOLD);
        end
        reset = 1'b1;
        step();
        checks++;
        if (state_dbg !== ST_WAIT_LOCK || snes_reset !== 1'b1 || running !== 1'b0 ||
            {mclk_ce, cpu_ce, dot_ce} !== 3'b000) begin
            errors++;
            $display("FAIL reset_in_hold: state %0d snes_reset %b running %b en %b, expected %0d 1 0 000",
                     state_dbg, snes_reset, running, {mclk_ce, cpu_ce, dot_ce}, ST_WAIT_LOCK);
        end
        // Reset while in RUN, one edge before a master pulse would fire.
        reset = 1'b0;
        cyc   = 0;
        exp_mclk_q.push_back(16'd23);
        exp_mclk_q.push_back(16'd27);
        while (cyc < 30) step();
        reset = 1'b1;
        step();
        checks++;
        if (state_dbg !== ST_WAIT_LOCK || snes_reset !== 1'b1 || running !== 1'b0 ||
            {mclk_ce, cpu_ce, dot_ce} !== 3'b000) begin
            errors++;
            $display("FAIL reset_in_run: state %0d snes_reset %b running %b en %b, expected %0d 1 0 000",
                     state_dbg, snes_reset, running, {mclk_ce, cpu_ce, dot_ce}, ST_WAIT_LOCK);
        end
        repeat (3) step();
        reset = 1'b0;
        checks++;
        if (exp_mclk_q.size() + exp_cpu_q.size() + exp_dot_q.size() != 0) begin
            errors++;
            $display("FAIL reset_pulses_pending: %0d/%0d/%0d pulses missing, expected 0/0/0",
                     exp_mclk_q.size(), exp_cpu_q.size(), exp_dot_q.size());
        end
        exp_mclk_q.delete(); exp_cpu_q.delete(); exp_dot_q.delete();
    endtask

    initial begin
        test_reset();
        test_lock_release();
        test_run_counts();
        test_speed_change();
        test_pause();
        test_lock_loss();
        test_reset_pulses();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snes_clkgen_rst.md
SNES_CLKGEN_RST -- requirements
Module: snes_clkgen_rst

Interface
REQ-001 SHALL have parameter MCLK_DIV, default 4, meaning fast-clock cycles per SNES master-clock enable (range 2..15).
REQ-002 SHALL have parameter RST_HOLD, default 1024, meaning fast-clock cycles of stable lock before reset release (range 4..65535).
REQ-003 SHALL have port clk, input, 1, fast system clock from PLL CLKOUT1 (86.4 MHz).
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pll_lock, input, 1, PLL lock indication, asynchronous to clk.
REQ-006 SHALL have port cpu_speed, input, 2, CPU cycle length: 0=6, 1=8, 2=12 master cycles, 3=8.
REQ-007 SHALL have port pause, input, 1, freezes all enables while high.
REQ-008 SHALL have port snes_reset, output, 1, active-high reset to the SNES core.
REQ-009 SHALL have port mclk_ce, output, 1, one-clk pulse per master cycle.
REQ-010 SHALL have port cpu_ce, output, 1, one-clk pulse per CPU cycle, coincident with mclk_ce.
REQ-011 SHALL have port dot_ce, output, 1, one-clk pulse every 4th master cycle, coincident with mclk_ce.
REQ-012 SHALL have port running, output, 1, high in RUN state.

Function
REQ-013 SHALL synchronise pll_lock through two flops; only lock_s (second flop) is used internally.
REQ-014 SHALL implement FSM states WAIT_LOCK, HOLD, RUN.
REQ-015 WAIT_LOCK -> HOLD when lock_s=1; hold counter cleared on entry.
REQ-016 HOLD: counter increments each clk; -> RUN on the clk where counter reaches RST_HOLD-1; lock_s=0 in HOLD -> WAIT_LOCK.
REQ-017 snes_reset SHALL be 1 in WAIT_LOCK and HOLD, 0 in RUN, registered (changes the clk after state entry).
REQ-018 mclk_ce, cpu_ce, dot_ce SHALL be 0 outside RUN.
REQ-019 In RUN with pause=0, a divider counter SHALL count 0..MCLK_DIV-1 and wrap; mclk_ce=1 for exactly one clk per wrap; first mclk_ce MCLK_DIV clks after RUN entry.
REQ-020 pause=1 SHALL hold divider, CPU and dot counters at current values and force all enables 0; resume continues from held values.
REQ-021 cpu counter SHALL advance on mclk_ce; cpu_ce asserted with mclk_ce that completes the selected cycle length.
REQ-022 cpu_speed SHALL be sampled only at CPU cycle boundaries (on cpu_ce); mid-cycle changes take effect for the next cycle.
REQ-023 dot counter (2 bits) SHALL advance on mclk_ce; dot_ce asserted with mclk_ce when counter wraps 3->0.
REQ-024 running SHALL equal (state==RUN), registered.

Reset
REQ-025 reset=1 SHALL force state WAIT_LOCK, all counters 0, snes_reset=1, all enables 0, running=0 on the next clk edge.
REQ-026 Synchroniser flops SHALL clear to 0 on reset.
REQ-027 Reset asserted mid-RUN SHALL abort immediately with no further enable pulses.

Configuration
REQ-028 Macro CLKGEN_LOCK_LOSS_RESET_EN SHALL be supported.
REQ-029 With CLKGEN_LOCK_LOSS_RESET_EN defined, lock_s=0 in RUN SHALL transition to WAIT_LOCK, re-asserting snes_reset the next clk.
REQ-030 Without it, RUN SHALL be left only via reset; lock_s ignored in RUN.

Structure
REQ-031 Shared package snes_clk_pkg SHALL hold the FSM state enum and cpu_speed encodings with their cycle-length constants (6/8/12).
REQ-032 Sub-module lock_sync (2-flop synchroniser, sync active-high reset) SHALL be instantiated for pll_lock.

Verification
REQ-033 pll_lock rises at clk 10, RST_HOLD=16 -> snes_reset falls exactly 2+16+1 clks after the pll_lock rise, running=1 same clk.
REQ-034 RUN, MCLK_DIV=4, cpu_speed=0 for 96 clks -> 24 mclk_ce, 4 cpu_ce, 6 dot_ce pulses.
REQ-035 cpu_speed 0->2 mid-CPU-cycle -> current cycle completes at 6 master cycles, next at 12.
REQ-036 pause high for 7 clks mid-divider -> no enables during pause; next mclk_ce occurs after remaining divider count post-release.
REQ-037 pll_lock drops in RUN -> with CLKGEN_LOCK_LOSS_RESET_EN snes_reset=1 within 4 clks; without, snes_reset stays 0 and enables continue.
REQ-038 reset pulsed in HOLD and in RUN -> next clk snes_reset=1, enables 0, state WAIT_LOCK.
